lock_seq_ctrl: RTL and testbench

LOCK_SEQ_CTRL -- requirements
Module: lock_seq_ctrl

---
 rtl/lock_seq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lock_seq_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_seq_ctrl.sv
//==============================================================================
// Module   : lock_seq_ctrl
// Purpose  : Front-end sequencer for a digit-entry lock core. Synchronises and
//            debounces a raw enter button, forwards one digit per press to the
//            core, interprets the core's unlocked/error responses, counts
//            consecutive failures, enforces a timed lockout and forces a
//            relock after a bounded unlocked period.
// Ports    : clk           - single clock
//            reset         - asynchronous, active-high reset
//            enter_btn     - raw, asynchronous, bouncy button level
//            in_digit      - user digit (4 bits)
//            lock_unlocked - core unlocked indication
//            lock_error    - core error indication
//            core_enter    - one-cycle enter pulse to the core
//            core_digit    - registered digit presented to the core
//            core_reset    - one-cycle relock pulse to the core
//            lockout_led   - high while locked out
//            fail_count    - consecutive-failure count
//            state_leds    - current state encoding
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lock_seq_ctrl #(
    parameter int DEB_CYCLES     = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int RELOCK_CYCLES  = 500,
    parameter int RESP_TIMEOUT   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_btn,
    input  logic [3:0] in_digit,
    input  logic       lock_unlocked,
    input  logic       lock_error,
    output logic       core_enter,
    output logic [3:0] core_digit,
    output logic       core_reset,
    output logic       lockout_led,
    output logic [1:0] fail_count,
    output logic [2:0] state_leds
);

    // Debounce counter only has to count up to DEB_CYCLES-1.
    localparam int              DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [15:0]     RESP_T   = 16'(RESP_TIMEOUT);
    localparam logic [15:0]     LOCK_T   = 16'(LOCKOUT_CYCLES);
    localparam logic [15:0]     RELOCK_T = 16'(RELOCK_CYCLES);
    localparam logic [1:0]      MAX_F    = 2'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_ISSUE   = 3'b001,
        S_WAIT    = 3'b010,
        S_OPEN    = 3'b011,
        S_LOCKOUT = 3'b100,
        S_RELOCK  = 3'b101
    } state_t;

    //--------------------------------------------------------------------------
    // Button synchroniser, debounce and rising-edge event
    //--------------------------------------------------------------------------
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             enter_evt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            enter_evt_q <= 1'b0;
        end else begin
            sync1_q     <= enter_btn;
            sync2_q     <= sync1_q;
            enter_evt_q <= 1'b0;
            if (sync2_q != deb_q) begin
                // Accept the new level on the DEB_CYCLES-th consecutive
                // differing sample; the event fires only on a 0->1 change.
                if (deb_cnt_q == DEB_LAST) begin
                    deb_q       <= sync2_q;
                    deb_cnt_q   <= '0;
                    enter_evt_q <= sync2_q;
                end else begin
                    deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                end
            end else begin
                // Any sample matching the accepted level restarts the count.
                deb_cnt_q <= '0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Sequencer FSM
    //--------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  fail_q,  fail_d;
    logic [3:0]  digit_q, digit_d;

    logic        timer_last;
    logic [1:0]  fail_inc;
    logic [15:0] timer_dec;

    // A timer value of 1 means this is the last cycle: the count reaches 0 on
    // the coming edge, so each timed state lasts exactly its loaded count.
    assign timer_last = (timer_q <= 16'd1);
    assign timer_dec  = timer_q - 16'd1;
    assign fail_inc   = (fail_q >= MAX_F) ? MAX_F : (fail_q + 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            fail_q  <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        digit_d = digit_q;
        case (state_q)
            S_IDLE: begin
                if (enter_evt_q) begin
                    digit_d = in_digit;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = RESP_T;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Error outranks a simultaneous unlocked indication.
                if (lock_error) begin
                    fail_d = fail_inc;
                    if (fail_inc == MAX_F) begin
                        timer_d = LOCK_T;
                        state_d = S_LOCKOUT;
                    end else begin
                        timer_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (lock_unlocked) begin
                    fail_d  = '0;
                    timer_d = RELOCK_T;
                    state_d = S_OPEN;
                end else if (timer_last) begin
                    // Silence from the core means the digit was accepted.
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_OPEN: begin
                if (enter_evt_q || timer_last) begin
                    timer_d = '0;
                    state_d = S_RELOCK;
                end else if (!lock_unlocked) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_LOCKOUT: begin
                if (timer_last) begin
                    timer_d = '0;
                    fail_d  = '0;
                    state_d = S_RELOCK;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_RELOCK: begin
                state_d = S_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register; pulses last exactly the
    // single cycle spent in ISSUE / RELOCK.
    assign core_enter  = (state_q == S_ISSUE);
    assign core_reset  = (state_q == S_RELOCK);
    assign lockout_led = (state_q == S_LOCKOUT);
    assign core_digit  = digit_q;
    assign fail_count  = fail_q;
    assign state_leds  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_lock_seq_ctrl.sv
//==============================================================================
// Module   : tb_lock_seq_ctrl
// Purpose  : Self-checking bench for lock_seq_ctrl. Directed scenarios plus a
//            randomized transaction loop, checked against a transaction-level
//            model of the expected behaviour (failure count, pulse counts,
//            state dwell times).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lock_seq_ctrl;

    localparam int DEB    = 2;
    localparam int MAXF   = 3;
    localparam int LOCK   = 20;
    localparam int RELOCK = 10;
    localparam int RESP   = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_OPEN   = 3'd3;
    localparam logic [2:0] ST_LOCK   = 3'd4;
    localparam logic [2:0] ST_RELOCK = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter_btn;
    logic [3:0] in_digit;
    logic       lock_unlocked;
    logic       lock_error;
    logic       core_enter;
    logic [3:0] core_digit;
    logic       core_reset;
    logic       lockout_led;
    logic [1:0] fail_count;
    logic [2:0] state_leds;

    int n_assert = 0;
    int n_fail   = 0;
    int n_enter  = 0;
    int n_reset  = 0;

    // Reference model state
    int         exp_fail   = 0;
    int         exp_enter  = 0;
    int         exp_reset  = 0;
    logic [3:0] last_digit = 4'd0;

    lock_seq_ctrl #(
        .DEB_CYCLES    (DEB),
        .MAX_FAILS     (MAXF),
        .LOCKOUT_CYCLES(LOCK),
        .RELOCK_CYCLES (RELOCK),
        .RESP_TIMEOUT  (RESP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enter_btn    (enter_btn),
        .in_digit     (in_digit),
        .lock_unlocked(lock_unlocked),
        .lock_error   (lock_error),
        .core_enter   (core_enter),
        .core_digit   (core_digit),
        .core_reset   (core_reset),
        .lockout_led  (lockout_led),
        .fail_count   (fail_count),
        .state_leds   (state_leds)
    );

    always #5 clk = ~clk;

    // Count high cycles of the pulse outputs; each legal pulse adds exactly one.
    always @(negedge clk) begin
        if (core_enter === 1'b1) n_enter <= n_enter + 1;
        if (core_reset === 1'b1) n_reset <= n_reset + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_enter"},  32'(core_enter),  0);
        chk({tag, "_core_reset"},  32'(core_reset),  0);
        chk({tag, "_lockout_led"}, 32'(lockout_led), 0);
        chk({tag, "_fail_count"},  32'(fail_count),  0);
        chk({tag, "_core_digit"},  32'(core_digit),  0);
        chk({tag, "_state"},       32'(state_leds),  32'(ST_IDLE));
    endtask

    // Button is already high: wait (bounded) for the single core_enter pulse.
    task automatic wait_issue(input logic [3:0] d, output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (core_enter === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("enter_pulse_seen", 32'(found), 1);
        chk("core_digit_latched", 32'(core_digit), 32'(d));
        chk("issue_state", 32'(state_leds), 32'(ST_ISSUE));
        exp_enter++;
        last_digit = d;
        chk("enter_pulse_count", 32'(n_enter), 32'(exp_enter));
        enter_btn = 1'b0;
    endtask

    // Lockout dwell. mode 1: press the button during lockout; mode 2: reset mid-lockout.
    task automatic lockout_phase(input int mode);
        int cnt;
        int ent0;
        chk("lockout_entry_state", 32'(state_leds), 32'(ST_LOCK));
        chk("lockout_entry_led", 32'(lockout_led), 1);
        chk("lockout_fail_sat", 32'(fail_count), 32'(MAXF));
        cnt  = 1;
        ent0 = n_enter;
        for (int i = 0; i < 200; i++) begin
            if (mode == 1 && i == 2) enter_btn = 1'b1;
            if (i == 9) enter_btn = 1'b0;
            if (mode == 2 && i == 5) begin
                reset = 1'b1;
                #1;
                chk_all_zero("reset_mid_lockout");
                step();
                reset = 1'b0;
                exp_fail   = 0;
                last_digit = 4'd0;
                repeat (LOCK + 5) step();
                chk("no_relock_after_abort", 32'(n_reset), 32'(exp_reset));
                chk("abort_lockout_idle", 32'(state_leds), 32'(ST_IDLE));
                return;
            end
            step();
            if (lockout_led !== 1'b1) break;
            cnt++;
        end
        enter_btn = 1'b0;
        chk("lockout_len", 32'(cnt), 32'(LOCK));
        chk("lockout_no_enter", 32'(n_enter), 32'(ent0));
        chk("lockout_end_relock", 32'(state_leds), 32'(ST_RELOCK));
        chk("lockout_end_core_reset", 32'(core_reset), 1);
        chk("lockout_end_fail_clear", 32'(fail_count), 0);
        exp_fail = 0;
        exp_reset++;
        step();
        chk("after_relock_idle", 32'(state_leds), 32'(ST_IDLE));
        chk("relock_one_cycle", 32'(core_reset), 0);
        chk("relock_pulse_count", 32'(n_reset), 32'(exp_reset));
    endtask

    // OPEN dwell. mode 0: idle until forced relock; 1: press in OPEN;
    // 2: core relocks on its own; 3: reset mid-OPEN.
    task automatic open_phase(input int mode, input int lat);
        int  cnt;
        int  l2;
        bit  found;
        case (mode)
            0: begin
                cnt = 1;
                for (int i = 0; i < 100; i++) begin
                    step();
                    if (state_leds !== ST_OPEN) break;
                    cnt++;
                end
                chk("open_dwell_len", 32'(cnt), 32'(RELOCK));
                chk("open_timeout_relock", 32'(state_leds), 32'(ST_RELOCK));
                chk("open_timeout_core_reset", 32'(core_reset), 1);
                exp_reset++;
                lock_unlocked = 1'b0;
                step();
                chk("open_timeout_idle", 32'(state_leds), 32'(ST_IDLE));
            end
            1: begin
                repeat (3) step();
                chk("open_still_open", 32'(state_leds), 32'(ST_OPEN));
                enter_btn = 1'b1;
                found = 1'b0;
                l2 = 0;
                for (int i = 0; i < 20; i++) begin
                    step();
                    l2++;
                    if (core_reset === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("open_press_relock_seen", 32'(found), 1);
                chk("open_press_latency", 32'(l2), 32'(lat));
                chk("open_press_state", 32'(state_leds), 32'(ST_RELOCK));
                chk("open_press_no_enter", 32'(n_enter), 32'(exp_enter));
                exp_reset++;
                enter_btn     = 1'b0;
                lock_unlocked = 1'b0;
                step();
                chk("open_press_idle", 32'(state_leds), 32'(ST_IDLE));
            end
            2: begin
                repeat (2) step();
                lock_unlocked = 1'b0;
                step();
                chk("open_unlock_drop_idle", 32'(state_leds), 32'(ST_IDLE));
                chk("open_unlock_drop_no_reset", 32'(core_reset), 0);
            end
            default: begin
                repeat (2) step();
                reset = 1'b1;
                #1;
                chk_all_zero("reset_mid_open");
                step();
                reset         = 1'b0;
                lock_unlocked = 1'b0;
                exp_fail      = 0;
                last_digit    = 4'd0;
                repeat (RELOCK + 4) step();
                chk("reset_open_idle", 32'(state_leds), 32'(ST_IDLE));
            end
        endcase
        chk("open_reset_pulse_count", 32'(n_reset), 32'(exp_reset));
    endtask

    // Core response handling, starting at the ISSUE sample.
    // resp 0: none, 1: error, 2: unlocked, 3: error and unlocked together.
    task automatic respond(input int resp, input int dly, input int mode, input int lat);
        int cnt;
        step();
        chk("enter_one_cycle", 32'(core_enter), 0);
        repeat (dly) step();
        chk("wait_state", 32'(state_leds), 32'(ST_WAIT));
        case (resp)
            0: begin
                cnt = 1 + dly;
                for (int i = 0; i < 40; i++) begin
                    step();
                    if (state_leds !== ST_WAIT) break;
                    cnt++;
                end
                chk("resp_timeout_len", 32'(cnt), 32'(RESP));
                chk("resp_timeout_idle", 32'(state_leds), 32'(ST_IDLE));
                chk("resp_timeout_fail_kept", 32'(fail_count), 32'(exp_fail));
                chk("core_digit_held", 32'(core_digit), 32'(last_digit));
            end
            1, 3: begin
                lock_error = 1'b1;
                if (resp == 3) lock_unlocked = 1'b1;
                step();
                lock_error    = 1'b0;
                lock_unlocked = 1'b0;
                exp_fail = (exp_fail + 1 > MAXF) ? MAXF : exp_fail + 1;
                chk("fail_count_after_error", 32'(fail_count), 32'(exp_fail));
                if (exp_fail == MAXF) begin
                    lockout_phase(mode);
                end else begin
                    chk("error_back_idle", 32'(state_leds), 32'(ST_IDLE));
                end
            end
            default: begin
                lock_unlocked = 1'b1;
                step();
                exp_fail = 0;
                chk("open_fail_cleared", 32'(fail_count), 0);
                chk("open_state", 32'(state_leds), 32'(ST_OPEN));
                open_phase(mode, lat);
            end
        endcase
        chk("enter_total", 32'(n_enter), 32'(exp_enter));
    endtask

    task automatic transact(input logic [3:0] d, input int resp, input int dly, input int mode);
        int lat;
        repeat (6) step();
        in_digit  = d;
        enter_btn = 1'b1;
        wait_issue(d, lat);
        respond(resp, dly, mode, lat);
    endtask

    initial begin
        int lat;
        reset         = 1'b1;
        enter_btn     = 1'b0;
        in_digit      = 4'd0;
        lock_unlocked = 1'b0;
        lock_error    = 1'b0;

        // Reset state
        repeat (3) step();
        chk_all_zero("in_reset");
        reset = 1'b0;
        step();
        chk_all_zero("after_reset");

        // Button held through reset release: no event inside 2+DEB cycles
        reset     = 1'b1;
        enter_btn = 1'b1;
        in_digit  = 4'hA;
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 2 + DEB; i++) begin
            step();
            chk("no_early_enter", 32'(core_enter), 0);
        end
        wait_issue(4'hA, lat);
        respond(0, 0, 0, lat);

        // Clean press of 0x5, no response from the core
        transact(4'h5, 0, 3, 0);

        // Single-cycle glitches are rejected
        repeat (6) begin
            enter_btn = 1'b1;
            step();
            enter_btn = 1'b0;
            repeat ($urandom_range(1, 4)) step();
        end
        repeat (8) step();
        chk("glitch_no_enter", 32'(n_enter), 32'(exp_enter));
        chk("glitch_idle", 32'(state_leds), 32'(ST_IDLE));

        // Three errors -> lockout, with a press attempted during lockout
        transact(4'($urandom), 1, 1, 0);
        transact(4'($urandom), 1, 4, 0);
        transact(4'($urandom), 1, 2, 1);

        // Unlock after two failures, then forced relock when idle
        transact(4'($urandom), 1, 0, 0);
        transact(4'($urandom), 1, 5, 0);
        transact(4'($urandom), 2, 2, 0);
        // Enter event while OPEN relocks immediately
        transact(4'($urandom), 2, 1, 1);

        // Simultaneous error and unlocked counts as a failure
        transact(4'($urandom), 3, 3, 0);
        // Reset mid-OPEN
        transact(4'($urandom), 2, 0, 3);
        // Reset mid-LOCKOUT
        transact(4'($urandom), 1, 0, 0);
        transact(4'($urandom), 3, 2, 0);
        transact(4'($urandom), 1, 1, 2);

        // Randomized transactions
        for (int k = 0; k < 14; k++) begin
            transact(4'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
